// File: rtl/zap_fetch_fifo_if.sv
// Handshake bundle between the fetch port, the prefetch buffer and the
// predecode stage. The buffer takes the slave view; the fetch/pipeline side
// takes the master view.
interface zap_fetch_fifo_if #(
  parameter int DEPTH = 4
) ();

  localparam int PTR_W = $clog2(DEPTH);

  // Pipeline control
  logic               i_flush;
  logic               i_stall;

  // Write side (fetch port)
  logic               i_wr_valid;
  logic [31:0]        i_wr_instr;
  logic [31:0]        i_wr_pc;
  logic               i_wr_abt;
  logic [1:0]         i_wr_taken;
  logic               o_wr_ready;

  // Read side (predecode head)
  logic [31:0]        o_instruction;
  logic               o_instruction_valid;
  logic [31:0]        o_pc_ff;
  logic [31:0]        o_pc_plus_8_ff;
  logic               o_abt;
  logic [1:0]         o_taken;
  logic [PTR_W:0]     o_count;

  modport slave (
    input  i_flush, i_stall,
    input  i_wr_valid, i_wr_instr, i_wr_pc, i_wr_abt, i_wr_taken,
    output o_wr_ready,
    output o_instruction, o_instruction_valid, o_pc_ff, o_pc_plus_8_ff,
    output o_abt, o_taken, o_count
  );

  modport master (
    output i_flush, i_stall,
    output i_wr_valid, i_wr_instr, i_wr_pc, i_wr_abt, i_wr_taken,
    input  o_wr_ready,
    input  o_instruction, o_instruction_valid, o_pc_ff, o_pc_plus_8_ff,
    input  o_abt, o_taken, o_count
  );

endinterface

// File: rtl/zap_fetch_fifo.sv
// Prefetch buffer between the instruction fetch port and predecode.
// Words are stored with PC, abort flag and predictor state and presented in
// order at the head. Every output depends only on registered state, so a
// stall or flush never reaches an output combinationally. A flush clears
// the pointers and occupancy; storage contents are left in place because
// they are unreachable once the occupancy is zero.
module zap_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  zap_fetch_fifo_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);

  // One stored fetch word: 32 + 32 + 1 + 2 = 67 bits
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        abt;
    logic [1:0]  taken;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_d;
  logic [PTR_W:0]     count_q;
  logic [PTR_W:0]     count_d;

  logic               wr_ready_s;
  logic               head_valid_s;
  logic               push_s;
  logic               pop_s;
  entry_t             wr_entry_s;
  entry_t             head_s;

  // Status flags derived purely from the occupancy register
  always_comb begin
    wr_ready_s   = (count_q != CNT_FULL);
    head_valid_s = (count_q != CNT_ZERO);
  end

  // Push/pop qualification; flush overrides both, and a full buffer refuses
  // a push even when the head is popped in the same cycle
  always_comb begin
    push_s = bus.i_wr_valid && wr_ready_s && !bus.i_flush;
    pop_s  = head_valid_s && !bus.i_stall && !bus.i_flush;
  end

  // Pack the incoming fetch word into a storage entry
  always_comb begin
    wr_entry_s.instr = bus.i_wr_instr;
    wr_entry_s.pc    = bus.i_wr_pc;
    wr_entry_s.abt   = bus.i_wr_abt;
    wr_entry_s.taken = bus.i_wr_taken;
  end

  // Next-state for pointers and occupancy; flush returns everything to empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: cleared by reset, written only on an accepted push
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  // Head selection; an empty buffer presents all-zero data
  always_comb begin
    head_s = '0;
    if (head_valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
  end

  // Drive the interface outputs from registered state only
  always_comb begin
    bus.o_wr_ready          = wr_ready_s;
    bus.o_instruction_valid = head_valid_s;
    bus.o_instruction       = head_s.instr;
    bus.o_pc_ff             = head_s.pc;
    bus.o_abt               = head_s.abt;
    bus.o_taken             = head_s.taken;
    bus.o_count             = count_q;
    if (head_valid_s) begin
      bus.o_pc_plus_8_ff = head_s.pc + 32'd8;
    end else begin
      bus.o_pc_plus_8_ff = 32'd0;
    end
  end

endmodule

// File: tb/tb_zap_fetch_fifo.sv
// Directed table-driven bench for the prefetch buffer (DEPTH = 4).
module tb_zap_fetch_fifo;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  zap_fetch_fifo_if #(.DEPTH(4)) bus_if ();

  zap_fetch_fifo #(.DEPTH(4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        stall;
    logic        vld;
    logic [31:0] pc;
    logic        exp_valid;
    logic        exp_ready;
    logic [2:0]  exp_count;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  // Word contents derived from the PC so the table only carries PCs
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction
  function automatic logic abt_of(input logic [31:0] pc);
    return pc[3];
  endfunction
  function automatic logic [1:0] taken_of(input logic [31:0] pc);
    return pc[3:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic s, input logic v,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic abt, input logic [1:0] tk);
    bus_if.i_flush    = f;
    bus_if.i_stall    = s;
    bus_if.i_wr_valid = v;
    bus_if.i_wr_instr = instr;
    bus_if.i_wr_pc    = pc;
    bus_if.i_wr_abt   = abt;
    bus_if.i_wr_taken = tk;
  endtask

  task automatic step(input logic f, input logic s, input logic v,
                      input logic [31:0] instr, input logic [31:0] pc,
                      input logic abt, input logic [1:0] tk);
    drive(f, s, v, instr, pc, abt, tk);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic f, input logic s, input logic v, input logic [31:0] pc,
                     input logic ev, input logic er, input logic [2:0] ec, input logic [31:0] epc);
    vec_t t;
    t.flush = f; t.stall = s; t.vld = v; t.pc = pc;
    t.exp_valid = ev; t.exp_ready = er; t.exp_count = ec; t.exp_pc = epc;
    vecs.push_back(t);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, bus_if.o_instruction_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus_if.o_wr_ready}, 32'd1);
    chk({tag, "_count"}, {29'd0, bus_if.o_count}, 32'd0);
    chk({tag, "_instr"}, bus_if.o_instruction, 32'd0);
    chk({tag, "_pc"}, bus_if.o_pc_ff, 32'd0);
    chk({tag, "_pc8"}, bus_if.o_pc_plus_8_ff, 32'd0);
    chk({tag, "_abt"}, {31'd0, bus_if.o_abt}, 32'd0);
    chk({tag, "_taken"}, {30'd0, bus_if.o_taken}, 32'd0);
  endtask

  initial begin
    logic [31:0] e_instr;
    logic [31:0] e_pc8;
    logic        e_abt;
    logic [1:0]  e_tk;
    total = 0;
    bad   = 0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("in_reset_valid", {31'd0, bus_if.o_instruction_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    chk_empty("reset");

    // Single push, visible next cycle, gone after a cycle with no push
    step(1'b0, 1'b0, 1'b1, 32'hE3A0_0001, 32'h100, 1'b0, 2'd2);
    chk("single_valid", {31'd0, bus_if.o_instruction_valid}, 32'd1);
    chk("single_instr", bus_if.o_instruction, 32'hE3A0_0001);
    chk("single_pc", bus_if.o_pc_ff, 32'h100);
    chk("single_pc8", bus_if.o_pc_plus_8_ff, 32'h108);
    chk("single_taken", {30'd0, bus_if.o_taken}, 32'd2);
    chk("single_count", {29'd0, bus_if.o_count}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    chk_empty("single_drain");

    // PC+8 wraps at 2^32
    step(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 1'b1, 2'd3);
    chk("wrap_pc8", bus_if.o_pc_plus_8_ff, 32'h0000_0004);
    chk("wrap_abt", {31'd0, bus_if.o_abt}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);

    // flush stall vld pc | valid ready count head_pc
    // Fill under stall; fifth word refused, head held at 0x0
    add(0, 1, 1, 32'h00, 1, 1, 3'd1, 32'h00);
    add(0, 1, 1, 32'h04, 1, 1, 3'd2, 32'h00);
    add(0, 1, 1, 32'h08, 1, 1, 3'd3, 32'h00);
    add(0, 1, 1, 32'h0C, 1, 0, 3'd4, 32'h00);
    add(0, 1, 1, 32'h10, 1, 0, 3'd4, 32'h00);
    // Release stall: pops in order
    add(0, 0, 0, 32'h00, 1, 1, 3'd3, 32'h04);
    add(0, 0, 0, 32'h00, 1, 1, 3'd2, 32'h08);
    add(0, 0, 0, 32'h00, 1, 1, 3'd1, 32'h0C);
    add(0, 0, 0, 32'h00, 0, 1, 3'd0, 32'h00);
    // Refill to full, then pop with a refused push
    add(0, 1, 1, 32'h20, 1, 1, 3'd1, 32'h20);
    add(0, 1, 1, 32'h24, 1, 1, 3'd2, 32'h20);
    add(0, 1, 1, 32'h28, 1, 1, 3'd3, 32'h20);
    add(0, 1, 1, 32'h2C, 1, 0, 3'd4, 32'h20);
    add(0, 0, 1, 32'h30, 1, 1, 3'd3, 32'h24);
    // Six push+pop cycles crossing the pointer wrap
    add(0, 0, 1, 32'h34, 1, 1, 3'd3, 32'h28);
    add(0, 0, 1, 32'h38, 1, 1, 3'd3, 32'h2C);
    add(0, 0, 1, 32'h3C, 1, 1, 3'd3, 32'h34);
    add(0, 0, 1, 32'h40, 1, 1, 3'd3, 32'h38);
    add(0, 0, 1, 32'h44, 1, 1, 3'd3, 32'h3C);
    add(0, 0, 1, 32'h48, 1, 1, 3'd3, 32'h40);
    // Flush with a word present: dropped; next push becomes the head
    add(1, 0, 1, 32'h4C, 0, 1, 3'd0, 32'h00);
    add(0, 0, 1, 32'h50, 1, 1, 3'd1, 32'h50);
    // Streaming: one word per cycle keeps count at 1
    add(0, 0, 1, 32'h54, 1, 1, 3'd1, 32'h54);
    add(0, 0, 1, 32'h58, 1, 1, 3'd1, 32'h58);
    add(0, 0, 0, 32'h00, 0, 1, 3'd0, 32'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].flush, vecs[i].stall, vecs[i].vld, instr_of(vecs[i].pc),
           vecs[i].pc, abt_of(vecs[i].pc), taken_of(vecs[i].pc));
      e_instr = vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'd0;
      e_pc8   = vecs[i].exp_valid ? vecs[i].exp_pc + 32'd8 : 32'd0;
      e_abt   = vecs[i].exp_valid ? abt_of(vecs[i].exp_pc) : 1'b0;
      e_tk    = vecs[i].exp_valid ? taken_of(vecs[i].exp_pc) : 2'd0;
      chk($sformatf("v%0d_valid", i), {31'd0, bus_if.o_instruction_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_ready", i), {31'd0, bus_if.o_wr_ready}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("v%0d_count", i), {29'd0, bus_if.o_count}, {29'd0, vecs[i].exp_count});
      chk($sformatf("v%0d_pc", i), bus_if.o_pc_ff, vecs[i].exp_pc);
      chk($sformatf("v%0d_pc8", i), bus_if.o_pc_plus_8_ff, e_pc8);
      chk($sformatf("v%0d_instr", i), bus_if.o_instruction, e_instr);
      chk($sformatf("v%0d_abt", i), {31'd0, bus_if.o_abt}, {31'd0, e_abt});
      chk($sformatf("v%0d_taken", i), {30'd0, bus_if.o_taken}, {30'd0, e_tk});
    end

    // Asynchronous reset between edges with two entries stored
    step(1'b0, 1'b1, 1'b1, instr_of(32'h60), 32'h60, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b1, instr_of(32'h64), 32'h64, 1'b1, 2'd1);
    chk("pre_arst_count", {29'd0, bus_if.o_count}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    #1 rst_n = 1'b0;
    #1;
    chk_empty("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    chk_empty("post_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
